ds1302_time_writer: RTL and testbench
=====================================

Name: ds1302_time_writer

Overview:
- Writes a new time/date into the DS1302 RTC over its 3-wire interface (CE, SCLK, IO).
- It is the write-side counterpart of the existing DS1302 reader.
- Sequence: clear write-protect, write seconds..year as seven single-byte writes, then set write-protect again.
- IO is output as a separate output value and output-enable pair, so the top level can share the one pin with the reader.

Parameters:
- CLK_DIV, default 50: clk cycles per SCLK half-period (500 kHz at 50 MHz clk); minimum 2.
- CE_GUARD, default 200: clk cycles of CE setup before the first SCLK rise, and CE-low gap between transactions (4 us at 50 MHz); minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request a write sequence; honoured only when busy=0
- wr_second  in  8  BCD seconds 00-59
- wr_minute  in  8  BCD minutes 00-59
- wr_hour  in  8  BCD hours 00-23 (24h mode)
- wr_date  in  8  BCD date 01-31
- wr_month  in  8  BCD month 01-12
- wr_week  in  8  BCD weekday 01-07
- wr_year  in  8  BCD year 00-99
- ds1302_ce  out  1  RTC chip enable
- ds1302_sclk  out  1  RTC serial clock
- ds1302_io_out  out  1  IO value to drive
- ds1302_io_oe  out  1  1 = drive IO pin
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when the sequence completes
- err  out  1  one-cycle pulse when a start is rejected (only with the optional feature)

Behaviour:
- Reset state: all outputs are 0; FSM is in IDLE. Reset mid-sequence aborts the sequence; CE, SCLK and OE are all 0 on the cycle after rst is sampled.
- Start: when start=1 in IDLE, all seven wr_* inputs are latched.
  - busy=1 and ce=1 from the next cycle.
  - start while busy=1 is ignored; later input changes have no effect.
- Transaction list (address, data), 9 in this order:
  - 0x8E, 0x00
  - 0x80, {1'b0, second[6:0]} (CH forced to 0, so the clock runs)
  - 0x82, minute
  - 0x84, {1'b0, hour[6:0]} (24h mode)
  - 0x86, date
  - 0x88, month
  - 0x8A, week
  - 0x8C, year
  - 0x8E, 0x80
- FSM per transaction:
  - CE_SETUP: CE_GUARD cycles; ce=1, sclk=0, oe=1, io_out = address bit0.
  - SHIFT_LOW / SHIFT_HIGH: 16 bits, address byte then data byte, each LSB first.
    - Each bit is CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1.
    - io_out changes only on entry to SHIFT_LOW, i.e. with or after the sclk falling edge, and is stable across the rising edge.
  - CE_HOLD: CLK_DIV cycles; sclk=0, ce=1, oe=1.
  - CE_GAP: CE_GUARD cycles; ce=0, oe=0, io_out=0. Then go to CE_SETUP of the next transaction, or to DONE after the 9th.
  - DONE: one cycle; done=1, busy=0 in the same cycle; then IDLE.
- Cycle counts:
  - Per transaction: 2*CE_GUARD + 33*CLK_DIV cycles (defaults: 2050).
  - Whole sequence: 9x that (defaults: 18450).
  - Timing: start sampled at edge N → ce=1 at N+1 → done=1 at N+1+18450.
- Exactly 16 SCLK rising edges occur per CE-high window; SCLK is 0 whenever CE changes.
- oe=1 only while ce=1. This block never reads IO.
- Counters: bit counter 0-15, transaction index 0-8, and a timer wide enough for max(CE_GUARD, CLK_DIV)-1.

Optional Feature:
- Macro: DS1302_WR_CHECK_EN.
- Defined: on an accepted start, the latched values are range-checked.
  - Every nibble must be <=9, and each field must be within its listed range (week 1-7, date 1-31, month 1-12).
  - On failure: err=1 for one cycle, FSM stays in IDLE, busy stays 0, and CE never rises.
- Undefined: no checking; err is tied to 0; values are written as given, except that bit7 of seconds and hours is forced to 0.

Test Plan:
- Defaults: start with time 23:59:58, date 31, month 12, week 7, year 99. A bench DS1302 model captures 9 transactions in the listed order with the listed bytes (sec 0x58, min 0x59, hour 0x23, ...); done arrives 18450 cycles after ce rises; busy falls with done.
- Seconds and hours with bit7 set: wr_second=0xD5, wr_hour=0x92 → written bytes are 0x55 and 0x12.
- start pulsed again mid-sequence, with inputs changed after the first start → still exactly 9 transactions, carrying the original values; no second sequence.
- rst asserted during the 4th transaction (at bit 9) → ce=0, sclk=0, oe=0, busy=0 the next cycle. A fresh start then produces the full 9 transactions from WP-clear.
- Timing check with CLK_DIV=4, CE_GUARD=3:
  - io_out is stable for CLK_DIV cycles before every sclk rise.
  - Exactly 16 rises per CE window; CE gap = 3 cycles.
  - Total cycles = 9*(6+132) = 1242.
- With DS1302_WR_CHECK_EN: wr_minute=0x60 → err pulses once, ce stays 0, done never asserts. A valid start afterwards completes normally.

Source files
------------

// File: rtl/ds1302_time_writer.sv
// DS1302 time/date writer: clears write-protect, writes seconds..year as
// seven single-byte 3-wire transactions, then sets write-protect again.
// IO is presented as a value/enable pair so the pin can be shared with the
// reader. Optional input range checking is enabled with DS1302_WR_CHECK_EN.
module ds1302_time_writer #(
  parameter int CLK_DIV  = 50,   // clk cycles per SCLK half-period
  parameter int CE_GUARD = 200   // CE setup and CE-low gap, in clk cycles
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] wr_second,
  input  logic [7:0] wr_minute,
  input  logic [7:0] wr_hour,
  input  logic [7:0] wr_date,
  input  logic [7:0] wr_month,
  input  logic [7:0] wr_week,
  input  logic [7:0] wr_year,
  output logic       ds1302_ce,
  output logic       ds1302_sclk,
  output logic       ds1302_io_out,
  output logic       ds1302_io_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int MAXC = (CE_GUARD > CLK_DIV) ? CE_GUARD : CLK_DIV;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] GUARD_M1 = TW'(CE_GUARD - 1);
  localparam logic [TW-1:0] DIV_M1   = TW'(CLK_DIV - 1);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] CE_SETUP   = 3'd1;
  localparam logic [2:0] SHIFT_LOW  = 3'd2;
  localparam logic [2:0] SHIFT_HIGH = 3'd3;
  localparam logic [2:0] CE_HOLD    = 3'd4;
  localparam logic [2:0] CE_GAP     = 3'd5;
  localparam logic [2:0] DONE       = 3'd6;

  logic [2:0]    state, state_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [3:0]    bit_cnt, bit_n;
  logic [3:0]    idx, idx_n;
  logic          accept, in_ok;
  logic [15:0]   word_n;
  logic          ce_n, sclk_n, io_n;

  // Latched time fields; bit7 of seconds/hours is always written as 0.
  logic [6:0] sec_q, hour_q;
  logic [7:0] min_q, date_q, month_q, week_q, year_q;

`ifdef DS1302_WR_CHECK_EN
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lo,
                                  input logic [7:0] hi);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
  endfunction

  assign in_ok = bcd_ok(wr_second, 8'h00, 8'h59) && bcd_ok(wr_minute, 8'h00, 8'h59) &&
                 bcd_ok(wr_hour,   8'h00, 8'h23) && bcd_ok(wr_date,   8'h01, 8'h31) &&
                 bcd_ok(wr_month,  8'h01, 8'h12) && bcd_ok(wr_week,   8'h01, 8'h07) &&
                 bcd_ok(wr_year,   8'h00, 8'h99);

  // One-cycle error pulse for a start rejected by the range check.
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= (state == IDLE) && start && !in_ok;
  end
`else
  logic unused_bits;
  assign unused_bits = &{1'b0, wr_second[7], wr_hour[7]};
  assign in_ok = 1'b1;
  assign err   = 1'b0;
`endif

  // Sequencer: per-transaction setup / 16-bit shift / hold / gap timing.
  always_comb begin
    state_n = state;
    tmr_n   = tmr - 1'b1;
    bit_n   = bit_cnt;
    idx_n   = idx;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        tmr_n = '0;
        if (start && in_ok) begin
          accept  = 1'b1;
          state_n = CE_SETUP;
          tmr_n   = GUARD_M1;
          idx_n   = 4'd0;
          bit_n   = 4'd0;
        end
      end
      CE_SETUP: if (tmr == '0) begin
        state_n = SHIFT_LOW;
        tmr_n   = DIV_M1;
      end
      SHIFT_LOW: if (tmr == '0) begin
        state_n = SHIFT_HIGH;
        tmr_n   = DIV_M1;
      end
      SHIFT_HIGH: if (tmr == '0) begin
        tmr_n = DIV_M1;
        if (bit_cnt == 4'd15) state_n = CE_HOLD;
        else begin
          state_n = SHIFT_LOW;
          bit_n   = bit_cnt + 4'd1;
        end
      end
      CE_HOLD: if (tmr == '0) begin
        state_n = CE_GAP;
        tmr_n   = GUARD_M1;
      end
      CE_GAP: if (tmr == '0) begin
        if (idx == 4'd8) begin
          state_n = DONE;
          tmr_n   = '0;
        end else begin
          state_n = CE_SETUP;
          tmr_n   = GUARD_M1;
          idx_n   = idx + 4'd1;
          bit_n   = 4'd0;
        end
      end
      default: begin
        state_n = IDLE;
        tmr_n   = '0;
      end
    endcase
  end

  // Address/data word for the upcoming transaction, shifted out LSB first.
  always_comb begin
    case (idx_n)
      4'd0:    word_n = {8'h00, 8'h8E};
      4'd1:    word_n = {1'b0, sec_q, 8'h80};
      4'd2:    word_n = {min_q, 8'h82};
      4'd3:    word_n = {1'b0, hour_q, 8'h84};
      4'd4:    word_n = {date_q, 8'h86};
      4'd5:    word_n = {month_q, 8'h88};
      4'd6:    word_n = {week_q, 8'h8A};
      4'd7:    word_n = {year_q, 8'h8C};
      default: word_n = {8'h80, 8'h8E};
    endcase
  end

  // Pin values for the next cycle; io only moves on entry to a low phase.
  always_comb begin
    ce_n   = (state_n == CE_SETUP) || (state_n == SHIFT_LOW) ||
             (state_n == SHIFT_HIGH) || (state_n == CE_HOLD);
    sclk_n = (state_n == SHIFT_HIGH);
    case (state_n)
      CE_SETUP:              io_n = word_n[0];
      SHIFT_LOW, SHIFT_HIGH: io_n = word_n[bit_n];
      CE_HOLD:               io_n = ds1302_io_out;
      default:               io_n = 1'b0;
    endcase
  end

  // State, counters, input latches and registered (glitch-free) pin outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tmr           <= '0;
      bit_cnt       <= '0;
      idx           <= '0;
      sec_q         <= '0;
      min_q         <= '0;
      hour_q        <= '0;
      date_q        <= '0;
      month_q       <= '0;
      week_q        <= '0;
      year_q        <= '0;
      ds1302_ce     <= 1'b0;
      ds1302_sclk   <= 1'b0;
      ds1302_io_out <= 1'b0;
      ds1302_io_oe  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      tmr           <= tmr_n;
      bit_cnt       <= bit_n;
      idx           <= idx_n;
      ds1302_ce     <= ce_n;
      ds1302_sclk   <= sclk_n;
      ds1302_io_out <= io_n;
      ds1302_io_oe  <= ce_n;
      busy          <= (state_n != IDLE) && (state_n != DONE);
      done          <= (state_n == DONE);
      if (accept) begin
        sec_q   <= wr_second[6:0];
        min_q   <= wr_minute;
        hour_q  <= wr_hour[6:0];
        date_q  <= wr_date;
        month_q <= wr_month;
        week_q  <= wr_week;
        year_q  <= wr_year;
      end
    end
  end

endmodule

// File: tb/tb_ds1302_time_writer.sv
// Bench for ds1302_time_writer: a default-parameter instance for the full
// timing sequence and a CLK_DIV=4 / CE_GUARD=3 instance for the rest.
// A cycle-position model and a DS1302-side capture model check the pins.
module tb_ds1302_time_writer;
  localparam int GA = 200, DA = 50, GB = 3, DB = 4;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sel = 1'b0;
  logic [7:0] wsec = 0, wmin = 0, whour = 0, wdate = 8'h01, wmon = 8'h01, wweek = 8'h01, wyear = 0;
  logic ce_a, sclk_a, io_a, oe_a, busy_a, done_a, err_a;
  logic ce_b, sclk_b, io_b, oe_b, busy_b, done_b, err_b;
  logic mo_ce, mo_sclk, mo_io, mo_oe, mo_busy, mo_done, mo_err;

  always #5 clk = ~clk;

  ds1302_time_writer #(.CLK_DIV(DA), .CE_GUARD(GA)) u_a (
    .clk(clk), .rst(rst), .start(start & ~sel),
    .wr_second(wsec), .wr_minute(wmin), .wr_hour(whour), .wr_date(wdate),
    .wr_month(wmon), .wr_week(wweek), .wr_year(wyear),
    .ds1302_ce(ce_a), .ds1302_sclk(sclk_a), .ds1302_io_out(io_a), .ds1302_io_oe(oe_a),
    .busy(busy_a), .done(done_a), .err(err_a));

  ds1302_time_writer #(.CLK_DIV(DB), .CE_GUARD(GB)) u_b (
    .clk(clk), .rst(rst), .start(start & sel),
    .wr_second(wsec), .wr_minute(wmin), .wr_hour(whour), .wr_date(wdate),
    .wr_month(wmon), .wr_week(wweek), .wr_year(wyear),
    .ds1302_ce(ce_b), .ds1302_sclk(sclk_b), .ds1302_io_out(io_b), .ds1302_io_oe(oe_b),
    .busy(busy_b), .done(done_b), .err(err_b));

  assign mo_ce   = sel ? ce_b   : ce_a;
  assign mo_sclk = sel ? sclk_b : sclk_a;
  assign mo_io   = sel ? io_b   : io_a;
  assign mo_oe   = sel ? oe_b   : oe_a;
  assign mo_busy = sel ? busy_b : busy_a;
  assign mo_done = sel ? done_b : done_a;
  assign mo_err  = sel ? err_b  : err_a;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model: m_t = cycles since CE first rose in the sequence, -1 when idle.
  int m_t = -1;
  logic m_err = 1'b0;
  bit seen_rst = 0;
  logic [7:0] m_data [9];
  logic [7:0] m_addr [9] = '{8'h8E, 8'h80, 8'h82, 8'h84, 8'h86, 8'h88, 8'h8A, 8'h8C, 8'h8E};

  function automatic bit in_range(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
    return (v[7:4] <= 9) && (v[3:0] <= 9) && (v >= lo) && (v <= hi);
  endfunction

  function automatic bit inputs_valid();
`ifdef DS1302_WR_CHECK_EN
    return in_range(wsec, 8'h00, 8'h59) && in_range(wmin, 8'h00, 8'h59) &&
           in_range(whour, 8'h00, 8'h23) && in_range(wdate, 8'h01, 8'h31) &&
           in_range(wmon, 8'h01, 8'h12) && in_range(wweek, 8'h01, 8'h07) &&
           in_range(wyear, 8'h00, 8'h99);
`else
    return 1'b1;
`endif
  endfunction

  // DS1302-side capture: words seen on SCLK rises, rise counts, CE-low gaps.
  logic [15:0] cap_q [$];
  int rise_q [$];
  int gap_q [$];

  initial begin
    int g, d, p, k, r, b, nb, gap_cnt, io_hold;
    logic [15:0] w, cap;
    logic [6:0] act, exp;
    logic eio, io_chk, p_ce, p_sclk, p_io;
    nb = 0; gap_cnt = 100000; io_hold = 0; cap = '0;
    p_ce = 1'b0; p_sclk = 1'b0; p_io = 1'b0;
    forever begin
      @(negedge clk);
      g = sel ? GB : GA;
      d = sel ? DB : DA;
      p = 2 * g + 33 * d;
      if (seen_rst) begin
        exp = '0; eio = 1'b0; io_chk = 1'b1;
        if (m_t < 0) exp[0] = m_err;
        else if (m_t == 9 * p) exp[1] = 1'b1;
        else begin
          k = m_t / p; r = m_t % p;
          w = {m_data[k], m_addr[k]};
          exp[2] = 1'b1;
          if (r < g) begin
            exp[6] = 1'b1; exp[4] = 1'b1; eio = w[0];
          end else if (r < g + 32 * d) begin
            b = (r - g) / (2 * d);
            exp[6] = 1'b1; exp[4] = 1'b1;
            exp[5] = ((r - g) % (2 * d)) >= d;
            eio = w[b];
          end else if (r < g + 33 * d) begin
            exp[6] = 1'b1; exp[4] = 1'b1; io_chk = 1'b0;
          end
        end
        act = {mo_ce, mo_sclk, mo_oe, 1'b0, mo_busy, mo_done, mo_err};
        chk("cycle_ctl{ce,sclk,oe,0,busy,done,err}", int'(act), int'(exp));
        if (io_chk) chk("cycle_io", int'(mo_io), int'(eio));

        if (mo_ce && !p_ce) begin
          chk("sclk_low_at_ce_rise", int'(mo_sclk), 0);
          gap_q.push_back(gap_cnt);
          cap = '0; nb = 0;
        end
        if (!mo_ce && p_ce) begin
          chk("sclk_low_at_ce_fall", int'(mo_sclk), 0);
          cap_q.push_back(cap);
          rise_q.push_back(nb);
          gap_cnt = 0;
        end
        if (!mo_ce) gap_cnt++;
        io_hold = (mo_io == p_io) ? io_hold + 1 : 1;
        if (mo_ce && mo_sclk && !p_sclk) begin
          chk("io_stable_before_rise", int'(io_hold >= d + 1), 1);
          if (nb < 16) cap[nb] = mo_io;
          nb++;
        end
      end
      p_ce = mo_ce; p_sclk = mo_sclk; p_io = mo_io;

      // Advance the model with the inputs the next rising edge will sample.
      if (rst) begin
        m_t = -1; m_err = 1'b0; seen_rst = 1;
      end else begin
        m_err = 1'b0;
        if (m_t < 0) begin
          if (start) begin
            if (inputs_valid()) begin
              m_t = 0;
              m_data = '{8'h00, wsec & 8'h7F, wmin, whour & 8'h7F, wdate, wmon, wweek, wyear, 8'h80};
            end else m_err = 1'b1;
          end
        end else if (m_t == 9 * p) m_t = -1;
        else m_t++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic set_time(input logic [7:0] s, mi, h, dt, mo, wk, y);
    wsec = s; wmin = mi; whour = h; wdate = dt; wmon = mo; wweek = wk; wyear = y;
  endtask

  task automatic clr();
    cap_q.delete(); rise_q.delete(); gap_q.delete();
  endtask

  // Cycles from pulse_start return until done, or a FAIL after the limit.
  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (mo_done) break;
      if (cyc > limit) begin
        chk("done_timeout", 0, 1);
        break;
      end
    end
    chk("busy_low_with_done", int'(mo_busy), 0);
  endtask

  // Hand-computed data bytes, first transaction in the top byte.
  task automatic check_seq(input logic [71:0] dat);
    logic [71:0] adr;
    adr = 72'h8E_80_82_84_86_88_8A_8C_8E;
    chk("txn_count", cap_q.size(), 9);
    for (int i = 0; i < 9 && i < cap_q.size(); i++) begin
      chk("txn_addr", int'(cap_q[i][7:0]), int'(adr[71-8*i -: 8]));
      chk("txn_data", int'(cap_q[i][15:8]), int'(dat[71-8*i -: 8]));
      chk("txn_rises", rise_q[i], 16);
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_outputs_a", int'({ce_a, sclk_a, oe_a, io_a, busy_a, done_a, err_a}), 0);
    chk("reset_outputs_b", int'({ce_b, sclk_b, oe_b, io_b, busy_b, done_b, err_b}), 0);
    rst = 1'b0;
    tick();

    // Default parameters: 23:59:58, 31/12, weekday 7, year 99.
    clr();
    set_time(8'h58, 8'h59, 8'h23, 8'h31, 8'h12, 8'h07, 8'h99);
    pulse_start();
    chk("ce_after_start", int'(ce_a), 1);
    chk("busy_after_start", int'(busy_a), 1);
    set_time(8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00);
    wait_done(20000, cyc);
    chk("seq_cycles_default", cyc - 1, 18450);
    check_seq(72'h00_58_59_23_31_12_07_99_80);
    tick();
    sel = 1'b1;
    tick();

    // Bit7 of seconds and hours is dropped; timing of the small instance.
    clr();
    set_time(8'hD5, 8'h00, 8'h92, 8'h01, 8'h01, 8'h01, 8'h00);
`ifdef DS1302_WR_CHECK_EN
    set_time(8'h55, 8'h00, 8'h12, 8'h01, 8'h01, 8'h01, 8'h00);
`endif
    pulse_start();
    wait_done(2000, cyc);
    chk("seq_cycles_small", cyc - 1, 1242);
    check_seq(72'h00_55_00_12_01_01_01_00_80);
    chk("gap_count", gap_q.size(), 9);
    for (int i = 1; i < 9 && i < gap_q.size(); i++) chk("ce_gap", gap_q[i], 3);
    tick();

    // Second start mid-sequence with new inputs is ignored.
    clr();
    set_time(8'h10, 8'h20, 8'h05, 8'h15, 8'h06, 8'h03, 8'h24);
    pulse_start();
    repeat (300) tick();
    set_time(8'h44, 8'h44, 8'h11, 8'h11, 8'h11, 8'h04, 8'h11);
    pulse_start();
    wait_done(2000, cyc);
    check_seq(72'h00_10_20_05_15_06_03_24_80);
    repeat (300) tick();
    chk("no_second_seq", cap_q.size(), 9);

    // Reset during the 4th transaction at bit 9, then a fresh sequence.
    clr();
    set_time(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07);
    pulse_start();
    repeat (3 * 138 + 3 + 9 * 8 - 1) tick();
    rst = 1'b1;
    tick();
    chk("rst_abort{ce,sclk,oe,busy}", int'({ce_b, sclk_b, oe_b, busy_b}), 0);
    rst = 1'b0;
    tick();
    clr();
    pulse_start();
    wait_done(2000, cyc);
    chk("seq_cycles_after_rst", cyc - 1, 1242);
    check_seq(72'h00_01_02_03_04_05_06_07_80);
    tick();

    // Out-of-range minute: rejected with err, or written as given.
    clr();
    set_time(8'h00, 8'h60, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00);
    pulse_start();
`ifdef DS1302_WR_CHECK_EN
    chk("err_pulse", int'(err_b), 1);
    chk("err_busy_low", int'(busy_b), 0);
    tick();
    chk("err_one_cycle", int'(err_b), 0);
    repeat (200) tick();
    chk("no_ce_after_err", cap_q.size() + gap_q.size(), 0);
    set_time(8'h00, 8'h30, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00);
    pulse_start();
    wait_done(2000, cyc);
    check_seq(72'h00_00_30_00_01_01_01_00_80);
`else
    chk("err_tied_low", int'(err_b), 0);
    wait_done(2000, cyc);
    check_seq(72'h00_00_60_00_01_01_01_00_80);
`endif
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
